sseg_scan: RTL

Time-multiplexed seven-segment display driver for the board's common-anode/cathode digit arrays. It takes a packed multi-digit nibble word and converts each nibble to segments (decimal or full hex glyphs). It scans the digits one at a time with a programmable per-digit slot, PWM brightness, per-digit decimal points and leading-zero blanking. It sits between the application's display register and the top-level segment/anode pins, and replaces the purely combinational decode path.

---
 rtl/sseg_pkg.sv | 23 ++
 rtl/sseg_glyph.sv | 17 +
 rtl/sseg_scan.sv | 118 +++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver:
// glyph table, segment bit positions and the blank value.
package sseg_pkg;

  localparam logic [6:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  localparam logic [7:0] OFF = 8'h00;

endpackage

// File: rtl/sseg_glyph.sv
// Nibble to active-high a..g segments; A-F blank
// unless hex glyphs are enabled.
module sseg_glyph
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_en,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[nib];
    if (!hex_en && nib > 4'd9)
      seg = 7'h00;
  end

endmodule

// File: rtl/sseg_scan.sv
// Multiplexed seven-segment scanner with frame
// snapshot, PWM dimming and leading-zero blanking.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int DIV_W   = 17,
  parameter int SEG_LOW = 1,
  parameter int AN_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   dat,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  hex_en,
  input  logic                  lz_en,
  input  logic [2:0]            bright,
  input  logic                  en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_strb
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_INV =
    (SEG_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_INV =
    (AN_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]  p;
  logic [IW-1:0]     idx;
  logic [3:0]        nib_s [DIGITS];
  logic [DIGITS-1:0] dp_s;
  logic              hex_s;
  logic              lz_s;
  logic              p_max;
  logic              snap;
  logic [DIGITS-1:0] blank;
  logic              run;
  logic [6:0]        glyph;
  logic              lit;
  logic [7:0]        seg_n;
  logic [DIGITS-1:0] an_n;

  assign p_max = (p == '1);
  assign snap  = p_max && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      idx <= '0;
    end else begin
      p <= p + 1'b1;
      if (p_max)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++)
        nib_s[i] <= '0;
      dp_s  <= '0;
      hex_s <= 1'b0;
      lz_s  <= 1'b0;
    end else if (snap) begin
      for (int i = 0; i < DIGITS; i++)
        nib_s[i] <= dat[4*i +: 4];
      dp_s  <= dp;
      hex_s <= hex_en;
      lz_s  <= lz_en;
    end
  end

  // Blanking runs from the top digit down and stops
  // at the first non-zero nibble or set dp.
  always_comb begin
    blank = '0;
    run   = lz_s;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run      = run && (nib_s[i] == 4'd0) && !dp_s[i];
      blank[i] = run;
    end
  end

  sseg_glyph u_glyph (
    .nib    (nib_s[idx]),
    .hex_en (hex_s),
    .seg    (glyph)
  );

  assign lit = en
            && (p[DIV_W-1 -: 3] <= bright)
            && !blank[idx];

  always_comb begin
    seg_n = OFF;
    an_n  = '0;
    if (lit) begin
      an_n                = DIGITS'(1) << idx;
      seg_n[SEG_DP]       = dp_s[idx];
      seg_n[SEG_A:SEG_G]  = glyph;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= OFF ^ SEG_INV;
      an         <= AN_INV;
      frame_strb <= 1'b0;
    end else begin
      seg        <= seg_n ^ SEG_INV;
      an         <= an_n ^ AN_INV;
      frame_strb <= snap;
    end
  end

endmodule
